// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON-128 initialization controller.
package ascon_pkg;

  // Five 64-bit state words; index i holds word xi.
  typedef logic [4:0][63:0] ascon_state_t;

  localparam logic [63:0] ASCON128_IV     = 64'h80400C0600000000;
  localparam int unsigned ASCON_PA_ROUNDS = 12;

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} init_state_e;

endpackage

// File: rtl/ascon_init_ctrl.sv
// ASCON-128 initialization controller: accepts K/N, builds IV||K||N, runs the
// 12-round permutation, XORs K into x3/x4 and hands the state downstream.
// Optional permutation watchdog: define ASCON_INIT_TIMEOUT_EN.
module ascon_init_ctrl
  import ascon_pkg::*;
#(
  parameter logic [63:0] IV        = ASCON128_IV,
  parameter int unsigned PA_ROUNDS = ASCON_PA_ROUNDS
`ifdef ASCON_INIT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      key,
  input  logic [127:0]      nonce,
  output logic              perm_start,
  output logic [3:0]        perm_rounds,
  output logic [4:0][63:0]  perm_state_in,
  input  logic [4:0][63:0]  perm_state_out,
  input  logic              perm_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0][63:0]  state_out,
  output logic              busy,
  output logic              err
);

  init_state_e  state, state_n;
  logic [127:0] key_q;
  logic         err_n;
  logic         wd_hit;

  assign perm_rounds = 4'(PA_ROUNDS);
  assign busy        = (state != IDLE);

`ifdef ASCON_INIT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  assign wd_hit = (state == WAIT) && !perm_done && (cnt == CNT_W'(TIMEOUT - 1));

  // Watchdog: counter is zero outside WAIT, so it starts from zero on entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= err_n;
      if (state != WAIT) cnt <= '0;
      else               cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign wd_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // Next-state logic; err_n is the sticky error flag's next value.
  always_comb begin
    state_n = state;
    err_n   = err | wd_hit;
    case (state)
      IDLE:    if (in_valid && in_ready) state_n = START;
      START:   state_n = WAIT;
      WAIT:    if (perm_done)    state_n = OUT;
               else if (wd_hit)  state_n = IDLE;
      OUT:     if (out_ready)    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register, registered handshake outputs and datapath capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      perm_start    <= 1'b0;
      out_valid     <= 1'b0;
      key_q         <= '0;
      perm_state_in <= '0;
      state_out     <= '0;
    end else begin
      state      <= state_n;
      // Outputs decoded from the next state so they are flops, not comb paths.
      in_ready   <= (state_n == IDLE) && !err_n;
      perm_start <= (state_n == START);
      out_valid  <= (state_n == OUT);
      if (state == IDLE && state_n == START) begin
        key_q            <= key;
        perm_state_in[0] <= IV;
        perm_state_in[1] <= key[127:64];
        perm_state_in[2] <= key[63:0];
        perm_state_in[3] <= nonce[127:64];
        perm_state_in[4] <= nonce[63:0];
      end
      if (state == WAIT && perm_done) begin
        state_out[0] <= perm_state_out[0];
        state_out[1] <= perm_state_out[1];
        state_out[2] <= perm_state_out[2];
        state_out[3] <= perm_state_out[3] ^ key_q[127:64];
        state_out[4] <= perm_state_out[4] ^ key_q[63:0];
      end
    end
  end

endmodule

// File: tb/tb_ascon_init_ctrl.sv
// Scoreboard bench for ascon_init_ctrl with a 12-cycle permutation model.
module tb_ascon_init_ctrl;
  import ascon_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, perm_start, perm_done;
  logic         out_valid, out_ready, busy, err;
  logic [127:0] key, nonce;
  logic [3:0]   perm_rounds;
  ascon_state_t perm_state_in, perm_state_out, state_out;

  int n_vec = 0;
  int n_err = 0;
  int n_ps  = 0;
  int n_hs  = 0;
  bit saw_ov = 0;
  int model_mode = 0;   // 0: identity, 1: all-ones, 2: never finishes
  ascon_state_t sb[$];

  always #5 clk = ~clk;

  ascon_init_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .nonce(nonce), .perm_start(perm_start), .perm_rounds(perm_rounds),
    .perm_state_in(perm_state_in), .perm_state_out(perm_state_out),
    .perm_done(perm_done), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ascon_state_t expect_of(input logic [127:0] k, input logic [127:0] n,
                                             input int mode);
    ascon_state_t s;
    if (mode == 0) begin
      s[0] = 64'h80400C0600000000;
      s[1] = k[127:64]; s[2] = k[63:0];
      s[3] = n[127:64]; s[4] = n[63:0];
    end else begin
      s = '1;
    end
    s[3] = s[3] ^ k[127:64];
    s[4] = s[4] ^ k[63:0];
    return s;
  endfunction

  // Permutation model: perm_done is high 12 cycles after the perm_start cycle.
  initial begin : model
    ascon_state_t snap;
    int mode;
    perm_done = 1'b0;
    perm_state_out = '0;
    forever begin
      @(negedge clk);
      if (perm_start && model_mode != 2) begin
        snap = perm_state_in;
        mode = model_mode;
        repeat (12) @(posedge clk);
        #1;
        perm_done = 1'b1;
        perm_state_out = (mode == 0) ? snap : '1;
        @(posedge clk);
        #1;
        perm_done = 1'b0;
        perm_state_out = '0;
      end
    end
  end

  // Monitor: pulse width, output stability under backpressure, scoreboard pop.
  initial begin : mon
    ascon_state_t last, e;
    bit held = 0;
    bit prev_ps = 0;
    forever begin
      @(negedge clk);
      if (perm_start) begin
        chk("ps_width", 64'(prev_ps), 64'd0);
        if (!prev_ps) n_ps++;
      end
      prev_ps = perm_start;
      if (out_valid) saw_ov = 1;
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 5; i++) chk($sformatf("hold_x%0d", i), state_out[i], last[i]);
      end
      if (rst_n && out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            for (int i = 0; i < 5; i++) chk($sformatf("out_x%0d", i), state_out[i], e[i]);
          end
          n_hs++;
          held = 0;
        end else begin
          held = 1;
          last = state_out;
        end
      end else begin
        held = 0;
      end
    end
  end

  // Presents K/N (in_valid left high) and returns just after the accept edge.
  task automatic offer(input logic [127:0] k, input logic [127:0] n, input int mode,
                       input bit push);
    bit ok = 0;
    key = k; nonce = n; in_valid = 1'b1; model_mode = mode;
    if (push) sb.push_back(expect_of(k, n, mode));
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  initial begin : stim
    int lat, ps0, hs0;
    logic [127:0] k2, n2;
    ascon_state_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; key = '0; nonce = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_perm_start", 64'(perm_start), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_state_out", 64'(state_out != '0), 64'd0);
    chk("rst_perm_in", 64'(perm_state_in != '0), 64'd0);
    chk("perm_rounds", 64'(perm_rounds), 64'd12);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Known-answer vector, identity permutation.
    offer(128'h000102030405060708090A0B0C0D0E0F, 128'h101112131415161718191A1B1C1D1E1F, 0, 1);
    in_valid = 1'b0;
    e = expect_of(128'h000102030405060708090A0B0C0D0E0F, 128'h101112131415161718191A1B1C1D1E1F, 0);
    e[3] = 64'h1011121314151617; e[4] = 64'h18191A1B1C1D1E1F;
    for (int i = 0; i < 5; i++) chk($sformatf("perm_in_x%0d", i), perm_state_in[i], e[i]);
    chk("busy_active", 64'(busy), 64'd1);
    wait_out(lat);
    chk("latency", 64'(lat), 64'd13);
    repeat (3) @(posedge clk);

    // Zero key/nonce, all-ones permutation.
    #1 offer('0, '0, 1, 1);
    in_valid = 1'b0;
    wait_out(lat);
    chk("latency_ones", 64'(lat), 64'd13);
    repeat (3) @(posedge clk);

    // Backpressure: out_ready low for 20 cycles.
    #1 out_ready = 1'b0;
    offer({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, 1);
    in_valid = 1'b0;
    wait_out(lat);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);

    // Reset during WAIT; the late perm_done must be ignored.
    #1 offer({4{32'hDEADBEEF}}, {4{32'h0BADF00D}}, 0, 0);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    saw_ov = 0;
    chk("wrst_busy", 64'(busy), 64'd0);
    chk("wrst_in_ready", 64'(in_ready), 64'd1);
    chk("wrst_state_out", 64'(state_out != '0), 64'd0);
    chk("wrst_perm_in", 64'(perm_state_in != '0), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("wrst_no_out_valid", 64'(saw_ov), 64'd0);
    chk("wrst_idle", 64'(busy), 64'd0);

    // Back-to-back with in_valid held high.
    ps0 = n_ps; hs0 = n_hs;
    k2 = {$urandom, $urandom, $urandom, $urandom};
    n2 = {$urandom, $urandom, $urandom, $urandom};
    offer(128'h0123456789ABCDEF_FEDCBA9876543210, 128'h55AA55AA55AA55AA_33CC33CC33CC33CC, 0, 1);
    offer(k2, n2, 0, 1);
    chk("b2b_after_hs", 64'(n_hs - hs0), 64'd1);
    in_valid = 1'b0;
    wait_out(lat);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_pulses", 64'(n_ps - ps0), 64'd2);

`ifdef ASCON_INIT_TIMEOUT_EN
    // Permutation never finishes: watchdog must fire after 64 WAIT cycles.
    saw_ov = 0;
    offer({4{32'hCAFEF00D}}, '0, 2, 0);
    in_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("wd_err_early", 64'(err), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("wd_err", 64'(err), 64'd1);
    chk("wd_in_ready", 64'(in_ready), 64'd0);
    chk("wd_busy", 64'(busy), 64'd0);
    chk("wd_no_out_valid", 64'(saw_ov), 64'd0);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
